// File: rtl/decoder3_8_pkg.sv
// Shared types and widths for the registered 3-to-8 one-hot decoder.
// The FSM encoding and the counter width helper live here.
package decoder3_8_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter must hold the larger of the two loads; never narrower than 1 bit.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    int w;
    m = (hold > gap) ? hold : gap;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/decoder3_8_comb.sv
// Purely combinational 3-bit binary to 8-bit one-hot decode, no enable.
module decoder3_8_comb
  import decoder3_8_pkg::*;
(
  input  logic [CODE_W-1:0]   a,
  output logic [ONEHOT_W-1:0] y
);

  assign y = {{(ONEHOT_W-1){1'b0}}, 1'b1} << a;

endmodule

// File: rtl/decoder3_8_seq.sv
// Registered one-hot decoder: accepts a code, holds its line for HOLD_CYCLES,
// then forces all lines low for GAP_CYCLES before accepting again.
module decoder3_8_seq
  import decoder3_8_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [CODE_W-1:0]   A,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] Y,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t               state_r, next_state_s;
  logic [CNT_W-1:0]     cnt_r, next_cnt_s;
  logic [ONEHOT_W-1:0]  y_r, next_y_s, dec_s;
  logic                 done_r, busy_r;
  logic                 accept_s;

  decoder3_8_comb u_comb (
    .a (A),
    .y (dec_s)
  );

  assign in_ready = (state_r == IDLE) && en && !rst;
  assign accept_s = in_valid && in_ready;

  // Next-state, counter and output-line selection.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_y_s     = y_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = DRIVE;
          next_cnt_s   = HOLD_LOAD;
          next_y_s     = dec_s;
        end else begin
          next_state_s = IDLE;
          next_cnt_s   = CNT_ZERO;
          next_y_s     = {ONEHOT_W{1'b0}};
        end
      end
      DRIVE: begin
        if (!en) begin
          next_state_s = IDLE;
          next_cnt_s   = CNT_ZERO;
          next_y_s     = {ONEHOT_W{1'b0}};
        end else if (cnt_r == CNT_ZERO) begin
          next_y_s = {ONEHOT_W{1'b0}};
          if (GAP_CYCLES == 0) begin
            next_state_s = IDLE;
            next_cnt_s   = CNT_ZERO;
          end else begin
            next_state_s = GAP;
            next_cnt_s   = GAP_LOAD;
          end
        end else begin
          next_cnt_s = cnt_r - CNT_ONE;
        end
      end
      GAP: begin
        next_y_s = {ONEHOT_W{1'b0}};
        if (!en || (cnt_r == CNT_ZERO)) begin
          next_state_s = IDLE;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = CNT_ZERO;
        next_y_s     = {ONEHOT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; done/busy are precomputed so they align with Y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      y_r     <= {ONEHOT_W{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      y_r     <= next_y_s;
      done_r  <= (next_state_s == DRIVE) && (next_cnt_s == CNT_ZERO);
      busy_r  <= (next_state_s != IDLE);
    end
  end

  assign Y    = y_r;
  assign done = done_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_decoder3_8_seq.sv
// Randomized bench for decoder3_8_seq: default build plus a HOLD=1/GAP=0 build
// whose output is decoded back to a code, both against a timeline reference model.
module tb_decoder3_8_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_s [2];
  logic       vld_s [2];
  logic [2:0] a_s [2];
  logic       rdy_s [2];
  logic [7:0] y_s [2];
  logic       busy_s [2];
  logic       done_s [2];

  always #5 clk = ~clk;

  decoder3_8_seq u_dut0 (
    .clk(clk), .rst(rst), .en(en_s[0]), .in_valid(vld_s[0]), .A(a_s[0]),
    .in_ready(rdy_s[0]), .Y(y_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  decoder3_8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en_s[1]), .in_valid(vld_s[1]), .A(a_s[1]),
    .in_ready(rdy_s[1]), .Y(y_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  // Unknown code bits at an accept are a stimulus error.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (vld_s[i] && rdy_s[i]) begin
        assert (!$isunknown(a_s[i])) else $error("unknown A at accept on dut%0d", i);
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: elapsed cycles since accept decides everything.
  int hold_c [2] = '{4, 1};
  int gap_c  [2] = '{1, 0};
  bit m_active [2];
  int m_k [2];
  int m_code [2];
  bit stepped_acc [2];
  int last_acc [2];
  bit spacing_chk = 1'b0;
  int done_cnt [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic int encode(input logic [7:0] y);
    int r = 0;
    for (int b = 0; b < 8; b++) if (y[b]) r = b;
    return r;
  endfunction

  task automatic step();
    bit en_pre [2];
    int code_pre [2];
    bit exp_rdy;
    logic [7:0] exp_y;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_rdy = !m_active[i] && en_s[i] && !rst;
      check($sformatf("ready%0d", i), rdy_s[i], exp_rdy);
      stepped_acc[i] = vld_s[i] && exp_rdy;
      en_pre[i]   = en_s[i];
      code_pre[i] = a_s[i];
      if (vld_s[i] && rdy_s[i]) begin
        if (spacing_chk && last_acc[i] >= 0)
          check($sformatf("spacing%0d", i), cyc - last_acc[i], hold_c[i] + gap_c[i] + 1);
        last_acc[i] = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) m_active[i] = 1'b0;
      else if (m_active[i]) begin
        if (!en_pre[i]) m_active[i] = 1'b0;
        else begin
          m_k[i]++;
          if (m_k[i] > hold_c[i] + gap_c[i]) m_active[i] = 1'b0;
        end
      end else if (stepped_acc[i]) begin
        m_active[i] = 1'b1;
        m_k[i]      = 1;
        m_code[i]   = code_pre[i];
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_y = (m_active[i] && m_k[i] <= hold_c[i]) ? (8'd1 << m_code[i]) : 8'd0;
      check($sformatf("y%0d", i), y_s[i], exp_y);
      check($sformatf("busy%0d", i), busy_s[i], m_active[i]);
      check($sformatf("done%0d", i), done_s[i], m_active[i] && m_k[i] == hold_c[i]);
      check($sformatf("onehot%0d", i), $onehot0(y_s[i]), 1);
      if (done_s[i]) done_cnt[i]++;
    end
    if (y_s[1] != 8'd0) check("roundtrip", encode(y_s[1]), m_code[1]);
  endtask

  int stream_code [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      en_s[i] = 1'($urandom); vld_s[i] = 1'($urandom); a_s[i] = 3'($urandom);
      m_active[i] = 1'b0; m_k[i] = 0; m_code[i] = 0; last_acc[i] = -1;
    end
    // Reset with random inputs
    repeat (3) begin
      for (int i = 0; i < 2; i++) begin
        en_s[i] = 1'($urandom); vld_s[i] = 1'($urandom); a_s[i] = 3'($urandom);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin en_s[i] = 1'b1; vld_s[i] = 1'b0; end
    rst = 1'b0;
    step();

    // Single code on both builds
    for (int i = 0; i < 2; i++) begin vld_s[i] = 1'b1; a_s[i] = 3'd5; end
    step();
    for (int i = 0; i < 2; i++) vld_s[i] = 1'b0;
    repeat (8) step();

    // Streaming 0..7 with in_valid held high
    spacing_chk = 1'b1;
    for (int i = 0; i < 2; i++) begin stream_code[i] = 0; last_acc[i] = -1; done_cnt[i] = 0; end
    while (stream_code[0] < 8 || stream_code[1] < 8) begin
      for (int i = 0; i < 2; i++) begin
        vld_s[i] = (stream_code[i] < 8);
        a_s[i]   = 3'(stream_code[i]);
      end
      step();
      for (int i = 0; i < 2; i++) if (stepped_acc[i]) stream_code[i]++;
      if (cyc > 400) begin
        check("stream_timeout", stream_code[0], 8);
        break;
      end
    end
    for (int i = 0; i < 2; i++) vld_s[i] = 1'b0;
    repeat (7) step();
    spacing_chk = 1'b0;
    check("stream_done0", done_cnt[0], 8);
    check("stream_done1", done_cnt[1], 8);

    // Abort in the second DRIVE cycle
    vld_s[0] = 1'b1; a_s[0] = 3'd6;
    step();
    vld_s[0] = 1'b0;
    step();
    en_s[0] = 1'b0;
    step();
    check("abort_y", y_s[0], 8'h00);
    repeat (2) step();
    en_s[0] = 1'b1;
    repeat (2) step();

    // Asynchronous reset mid-hold
    vld_s[0] = 1'b1; a_s[0] = 3'd3;
    step();
    vld_s[0] = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_y", y_s[0], 8'h00);
    check("rst_busy", busy_s[0], 1'b0);
    check("rst_ready", rdy_s[0], 1'b0);
    for (int i = 0; i < 2; i++) m_active[i] = 1'b0;
    step();
    rst = 1'b0;
    step();
    vld_s[0] = 1'b1; a_s[0] = 3'd1;
    step();
    vld_s[0] = 1'b0;
    check("after_rst_y", y_s[0], 8'h02);
    repeat (6) step();

    // Random traffic
    repeat (400) begin
      for (int i = 0; i < 2; i++) begin
        en_s[i]  = ($urandom_range(0, 9) != 0);
        vld_s[i] = 1'($urandom);
        a_s[i]   = 3'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
